// File: rtl/ones_checksum_accum_pkg.sv
// Shared types and default sizing for the ones'-complement checksum engine.
package ones_checksum_accum_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;
  localparam int DEF_W     = 4;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/ones_checksum_accum_if.sv
// Word stream in, checksum result out; master is the producer/consumer side.
interface ones_checksum_accum_if #(parameter int W = 4, parameter int CNT_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             sum_valid;
  logic             sum_ready;
  logic [W-1:0]     sum_data;
  logic [CNT_W-1:0] sum_count;

  modport master (output in_valid, in_data, in_last, sum_ready,
                  input  in_ready, sum_valid, sum_data, sum_count);
  modport slave  (input  in_valid, in_data, in_last, sum_ready,
                  output in_ready, sum_valid, sum_data, sum_count);
endinterface

// File: rtl/ones_checksum_accum_fold.sv
// Combinational W-bit ones'-complement add with end-around carry.
module oc_fold_add #(parameter int W = 4) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  logic [W:0] s;
  assign s = {1'b0, a} + {1'b0, b};
  // Re-adding the carry cannot overflow again: s[W-1:0] <= 2**W-2 when s[W]=1.
  assign y = s[W-1:0] + W'(s[W]);
endmodule

// File: rtl/ones_checksum_accum.sv
// Streaming ones'-complement checksum: folds packet words, emits ~sum and word count.
module ones_checksum_accum
  import ones_checksum_accum_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic                  clk,
  input logic                  rst,
  ones_checksum_accum_if.slave bus
);
  state_t           state, state_nxt;
  logic [W-1:0]     acc, fold_y, sum_data_q;
  logic [CNT_W-1:0] cnt, cnt_inc, sum_count_q;
  logic             accept, release_res;

  oc_fold_add #(.W(W)) u_fold (.a(acc), .b(bus.in_data), .y(fold_y));

  assign cnt_inc       = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign bus.sum_data  = sum_data_q;
  assign bus.sum_count = sum_count_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.sum_valid = 1'b0;
    accept        = 1'b0;
    release_res   = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        bus.in_ready = 1'b1;
        accept       = bus.in_valid;
        if (accept) state_nxt = bus.in_last ? DONE : ACCUM;
      end
      DONE: begin
        bus.sum_valid = 1'b1;
        release_res   = bus.sum_ready;
        if (bus.sum_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // acc/cnt are zero in IDLE, so the first beat uses the same fold path.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= '0;
      sum_data_q  <= '0;
      sum_count_q <= '0;
    end else if (accept) begin
      acc <= fold_y;
      cnt <= cnt_inc;
      if (bus.in_last) begin
        sum_data_q  <= ~fold_y;
        sum_count_q <= cnt_inc;
      end
    end else if (release_res) begin
      acc         <= '0;
      cnt         <= '0;
      sum_data_q  <= '0;
      sum_count_q <= '0;
    end
  end
endmodule
